// File: rtl/rsa256_byte_loader.sv
// Byte-stream loader for the RSA-256 core: assembles n, e, then ciphertext blocks MSB-first.
// Optional block range check (a >= n rejected) enabled by defining RSA_LOADER_RANGE_CHECK_EN.
module rsa256_byte_loader #(
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_byte_val,
    output logic               o_byte_rdy,
    input  logic [7:0]         i_byte,
    input  logic               i_key_clr,
    output logic               o_src_val,
    input  logic               i_src_rdy,
    output logic [255:0]       o_a,
    output logic [255:0]       o_e,
    output logic [255:0]       o_n,
    output logic               o_key_loaded,
    output logic [CNT_W-1:0]   o_blk_cnt,
    output logic               o_err
);

    typedef enum logic [1:0] {LOAD_N, LOAD_E, LOAD_A, SEND} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [4:0]         r_byte_cnt;
    logic [255:0]       r_n;
    logic [255:0]       r_e;
    logic [255:0]       r_a;
    logic               r_key_loaded;
    logic               r_src_val;
    logic [CNT_W-1:0]   r_blk_cnt;
    logic               r_err;
    logic               w_accept;
    logic               w_last;
    logic               w_reject;

    assign o_byte_rdy = (r_state != SEND);
    assign w_accept   = i_byte_val && o_byte_rdy && !i_key_clr;
    assign w_last     = w_accept && (r_byte_cnt == 5'd31);

`ifdef RSA_LOADER_RANGE_CHECK_EN
    logic [255:0] w_a_full;
    assign w_a_full = {r_a[247:0], i_byte};
    assign w_reject = w_last && (r_state == LOAD_A) && (w_a_full >= r_n);
`else
    assign w_reject = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD_N: if (w_last) w_state_next = LOAD_E;
            LOAD_E: if (w_last) w_state_next = LOAD_A;
            LOAD_A: if (w_last && !w_reject) w_state_next = SEND;
            SEND:   if (i_src_rdy) w_state_next = LOAD_A;
            default: w_state_next = LOAD_N;
        endcase
        // Key clear overrides every other transition.
        if (i_key_clr) w_state_next = LOAD_N;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= LOAD_N;
            r_byte_cnt   <= 5'd0;
            r_n          <= '0;
            r_e          <= '0;
            r_a          <= '0;
            r_key_loaded <= 1'b0;
            r_src_val    <= 1'b0;
            r_blk_cnt    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_src_val <= (w_state_next == SEND);
            r_err     <= w_reject;
            if (i_key_clr) begin
                r_byte_cnt   <= 5'd0;
                r_key_loaded <= 1'b0;
                r_blk_cnt    <= '0;
            end else begin
                if (w_accept) r_byte_cnt <= r_byte_cnt + 5'd1;
                if (r_state == LOAD_E && w_last) r_key_loaded <= 1'b1;
                if (r_state == SEND && i_src_rdy) r_blk_cnt <= r_blk_cnt + 1'b1;
            end
            // Operand registers keep their contents across a key clear.
            if (w_accept) begin
                case (r_state)
                    LOAD_N:  r_n <= {r_n[247:0], i_byte};
                    LOAD_E:  r_e <= {r_e[247:0], i_byte};
                    LOAD_A:  r_a <= {r_a[247:0], i_byte};
                    default: ;
                endcase
            end
        end
    end

    assign o_src_val    = r_src_val;
    assign o_a          = r_a;
    assign o_e          = r_e;
    assign o_n          = r_n;
    assign o_key_loaded = r_key_loaded;
    assign o_blk_cnt    = r_blk_cnt;
    assign o_err        = r_err;

endmodule
